// File: rtl/slot_allocator.sv
// Free-slot allocator: registered busy bitmap, lowest-free-index offer, one-hot view in LSB0/MSB0 order.
// Define SLOT_ALLOCATOR_ERROR_CHECK_EN to enable the sticky illegal-free error flag.
module slot_allocator #(
    parameter int NUM_SLOTS   = 4,
    parameter     DIRECTION   = "LSB0",
    parameter int INDEX_WIDTH = $clog2(NUM_SLOTS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           alloc_en,
    output logic                           alloc_valid,
    output logic [INDEX_WIDTH-1:0]         alloc_index,
    output logic [NUM_SLOTS-1:0]           alloc_oh,
    input  logic                           free_en,
    input  logic [INDEX_WIDTH-1:0]         free_index,
    output logic [$clog2(NUM_SLOTS+1)-1:0] free_count,
    output logic                           error
);

    localparam int CW = $clog2(NUM_SLOTS + 1);

    logic [NUM_SLOTS-1:0] busy;
    logic [NUM_SLOTS-1:0] sel;
    logic [NUM_SLOTS-1:0] free_sel;
    logic [NUM_SLOTS-1:0] busy_nxt;
    logic                 do_alloc;
    logic                 free_ok;

    // Offer is derived from registered state only, so a same-cycle free never shows up here.
    always_comb begin
        alloc_valid = 1'b0;
        alloc_index = '0;
        sel         = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!busy[i] && !alloc_valid) begin
                alloc_valid = 1'b1;
                alloc_index = INDEX_WIDTH'(i);
                sel[i]      = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_oh
        if (DIRECTION == "MSB0") begin : g_msb
            assign alloc_oh[NUM_SLOTS-1-g] = sel[g];
        end else begin : g_lsb
            assign alloc_oh[g] = sel[g];
        end
    end

    // Out-of-range indices decode to no slot at all, which makes them illegal frees.
    always_comb begin
        free_sel = '0;
        for (int i = 0; i < NUM_SLOTS; i++)
            if (free_index == INDEX_WIDTH'(i)) free_sel[i] = 1'b1;
    end

    assign do_alloc = alloc_en && alloc_valid;
    assign free_ok  = free_en && |(free_sel & busy);

    always_comb begin
        busy_nxt = busy;
        if (do_alloc) busy_nxt = busy_nxt | sel;
        if (free_ok)  busy_nxt = busy_nxt & ~free_sel;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            busy       <= '0;
            free_count <= CW'(NUM_SLOTS);
        end else begin
            busy <= busy_nxt;
            if (do_alloc && !free_ok)
                free_count <= free_count - CW'(1);
            else if (free_ok && !do_alloc)
                free_count <= free_count + CW'(1);
        end
    end

`ifdef SLOT_ALLOCATOR_ERROR_CHECK_EN
    logic error_q;

    always_ff @(posedge clk) begin
        if (!reset)
            error_q <= 1'b0;
        else if (free_en && !free_ok)
            error_q <= 1'b1;
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_slot_allocator.sv
// Self-checking bench for slot_allocator: a set-of-busy-slots model checked every cycle,
// directed scenarios with literal expectations, randomized traffic, plus a 5-slot MSB0 instance.
module tb_slot_allocator;

`ifdef SLOT_ALLOCATOR_ERROR_CHECK_EN
    localparam bit ERRCHK = 1'b1;
`else
    localparam bit ERRCHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       alloc_en, free_en;
    logic [1:0] free_index;
    logic       alloc_valid, error;
    logic [1:0] alloc_index;
    logic [3:0] alloc_oh;
    logic [2:0] free_count;

    logic       alloc_en5, free_en5;
    logic [2:0] free_index5;
    logic       alloc_valid5, error5;
    logic [2:0] alloc_index5;
    logic [4:0] alloc_oh5;
    logic [2:0] free_count5;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    slot_allocator u4 (
        .clk(clk), .reset(reset), .alloc_en(alloc_en), .alloc_valid(alloc_valid),
        .alloc_index(alloc_index), .alloc_oh(alloc_oh), .free_en(free_en),
        .free_index(free_index), .free_count(free_count), .error(error)
    );

    slot_allocator #(.NUM_SLOTS(5), .DIRECTION("MSB0")) u5 (
        .clk(clk), .reset(reset), .alloc_en(alloc_en5), .alloc_valid(alloc_valid5),
        .alloc_index(alloc_index5), .alloc_oh(alloc_oh5), .free_en(free_en5),
        .free_index(free_index5), .free_count(free_count5), .error(error5)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: the set of busy slots; the offer is simply the smallest slot not in the set.
    logic [3:0] m_busy;
    bit         m_err;

    function automatic int lowest_free(input logic [3:0] b);
        for (int i = 0; i < 4; i++)
            if (!b[i]) return i;
        return -1;
    endfunction

    function automatic logic [3:0] next_busy(input logic [3:0] b, input logic ae, input logic fe,
                                             input logic [1:0] fi);
        logic [3:0] n;
        int k;
        n = b;
        k = lowest_free(b);
        if (ae && k >= 0) n[k] = 1'b1;
        if (fe && b[fi]) n[fi] = 1'b0;
        return n;
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            m_busy <= 4'b0000;
            m_err  <= 1'b0;
        end else begin
            m_busy <= next_busy(m_busy, alloc_en, free_en, free_index);
            m_err  <= m_err | (ERRCHK && free_en && !m_busy[free_index]);
        end
    end

    int ck;
    always @(negedge clk) begin
        if (chk_on) begin
            ck = lowest_free(m_busy);
            chk("m_valid", 32'(alloc_valid), 32'(ck >= 0));
            chk("m_index", 32'(alloc_index), (ck >= 0) ? 32'(ck) : 32'd0);
            chk("m_oh",    32'(alloc_oh),    (ck >= 0) ? (32'd1 << ck) : 32'd0);
            chk("m_count", 32'(free_count),  32'(4 - $countones(m_busy)));
            chk("m_error", 32'(error),       32'(m_err));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] exp_oh [4];

    initial begin
        exp_oh = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        reset = 1'b0; alloc_en = 1'b0; free_en = 1'b0; free_index = '0;
        alloc_en5 = 1'b0; free_en5 = 1'b0; free_index5 = '0;
        step(); step();
        reset = 1'b1;
        chk_on = 1'b1;

        chk("rst_valid", 32'(alloc_valid), 32'd1);
        chk("rst_index", 32'(alloc_index), 32'd0);
        chk("rst_oh",    32'(alloc_oh),    32'b0001);
        chk("rst_count", 32'(free_count),  32'd4);
        chk("rst_error", 32'(error),       32'd0);

        // 5-slot MSB0 instance
        chk("m5_rst_oh",    32'(alloc_oh5),    32'b10000);
        chk("m5_rst_count", 32'(free_count5),  32'd5);
        alloc_en5 = 1'b1;
        chk("m5_first_idx", 32'(alloc_index5), 32'd0);
        step();
        alloc_en5 = 1'b0;
        chk("m5_idx1",   32'(alloc_index5), 32'd1);
        chk("m5_oh1",    32'(alloc_oh5),    32'b01000);
        chk("m5_count1", 32'(free_count5),  32'd4);
        free_en5 = 1'b1; free_index5 = 3'd6;
        step();
        free_en5 = 1'b0;
        chk("m5_oor_count", 32'(free_count5), 32'd4);
        chk("m5_oor_idx",   32'(alloc_index5), 32'd1);
        chk("m5_oor_err",   32'(error5),       32'(ERRCHK));
        alloc_en5 = 1'b1;
        repeat (4) step();
        alloc_en5 = 1'b0;
        chk("m5_full_valid", 32'(alloc_valid5), 32'd0);
        chk("m5_full_oh",    32'(alloc_oh5),    32'd0);
        chk("m5_full_count", 32'(free_count5),  32'd0);

        // fill all four slots in order
        alloc_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("fill_idx", 32'(alloc_index), 32'(i));
            chk("fill_oh",  32'(alloc_oh),    32'(exp_oh[i]));
            step();
        end
        alloc_en = 1'b0;
        chk("full_valid", 32'(alloc_valid), 32'd0);
        chk("full_oh",    32'(alloc_oh),    32'd0);
        chk("full_count", 32'(free_count),  32'd0);

        // free slot 2 while full; the concurrent alloc_en must be ignored
        alloc_en = 1'b1; free_en = 1'b1; free_index = 2'd2;
        step();
        alloc_en = 1'b0;
        chk("refree_valid", 32'(alloc_valid), 32'd1);
        chk("refree_idx",   32'(alloc_index), 32'd2);
        chk("refree_count", 32'(free_count),  32'd1);

        // leave slots 0,1 busy, then alloc slot 2 while freeing slot 0
        free_index = 2'd3;
        step();
        alloc_en = 1'b1; free_en = 1'b1; free_index = 2'd0;
        step();
        alloc_en = 1'b0; free_en = 1'b0;
        chk("swap_idx",   32'(alloc_index), 32'd0);
        chk("swap_count", 32'(free_count),  32'd2);

        // illegal free of slot 3 (currently free)
        free_en = 1'b1; free_index = 2'd3;
        step();
        free_en = 1'b0;
        chk("ill_err",   32'(error),      32'(ERRCHK));
        chk("ill_count", 32'(free_count), 32'd2);
        repeat (3) step();
        chk("ill_sticky", 32'(error), 32'(ERRCHK));

        // reset wins over concurrent alloc and free
        alloc_en = 1'b1; free_en = 1'b1; free_index = 2'd1; reset = 1'b0;
        step();
        reset = 1'b1; alloc_en = 1'b0; free_en = 1'b0;
        chk("rst2_count", 32'(free_count),  32'd4);
        chk("rst2_idx",   32'(alloc_index), 32'd0);
        chk("rst2_err",   32'(error),       32'd0);

        for (int n = 0; n < 600; n++) begin
            reset      = ($urandom_range(0, 59) != 0);
            alloc_en   = $urandom_range(0, 1);
            free_en    = ($urandom_range(0, 2) != 0);
            free_index = 2'($urandom_range(0, 3));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
